// File: rtl/dmem_arb_pkg.sv
// Shared encodings for dmem_arbiter: FSM states, address regions and MMIO offsets.
package dmem_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [16:0] REGION_DMEM  = 17'h0;
  localparam logic [16:0] REGION_MMIO  = 17'h1;
  localparam logic [14:0] MMIO_LED_OFS = 15'h0;

  typedef enum logic [1:0] {
    RGN_DMEM = 2'd0,
    RGN_MMIO = 2'd1,
    RGN_ERR  = 2'd2
  } region_e;

  // Maps addr[31:15] to the region it selects.
  function automatic region_e decode_region(input logic [16:0] i_region);
    region_e v_rgn;
    if (i_region == REGION_DMEM) begin
      v_rgn = RGN_DMEM;
    end else if (i_region == REGION_MMIO) begin
      v_rgn = RGN_MMIO;
    end else begin
      v_rgn = RGN_ERR;
    end
    return v_rgn;
  endfunction

endpackage

// File: rtl/dmem_mmio_regs.sv
// Board I/O window of dmem_arbiter: switch synchronizer, LED register, MMIO read data.
module dmem_mmio_regs #(
  parameter int LED_W = 27,
  parameter int SW_W  = 18
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [SW_W-1:0]  i_switches,
  input  logic             i_led_we,
  input  logic [LED_W-1:0] i_led_wdata,
  output logic [LED_W-1:0] o_leds,
  output logic [63:0]      o_rdata
);

  logic [SW_W-1:0]  r_sw_meta;
  logic [SW_W-1:0]  r_sw_sync;
  logic [LED_W-1:0] r_leds;

  // Two-flop synchronizer for the asynchronous switch inputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= i_switches;
      r_sw_sync <= r_sw_meta;
    end
  end

  // LED drive register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_leds <= '0;
    end else if (i_led_we) begin
      r_leds <= i_led_wdata;
    end else begin
      r_leds <= r_leds;
    end
  end

  assign o_leds  = r_leds;
  assign o_rdata = {{(64-SW_W){1'b0}}, r_sw_sync};

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory plus board I/O window.
// Optional macro DMEM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority to port 0.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_BITS = 14,
  parameter int LED_W     = 27,
  parameter int SW_W      = 18
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             r0_valid,
  input  logic             r1_valid,
  input  logic [63:0]      r0_addr,
  input  logic [63:0]      r1_addr,
  input  logic [63:0]      r0_wdata,
  input  logic [63:0]      r1_wdata,
  input  logic             r0_we,
  input  logic             r1_we,
  output logic             r0_done,
  output logic             r1_done,
  output logic [63:0]      r0_rdata,
  output logic [63:0]      r1_rdata,
  output logic             r0_err,
  output logic             r1_err,
  output logic             r0_stall,
  output logic [63:0]      mem_address,
  output logic [63:0]      mem_write_data,
  output logic             mem_MemWrite,
  output logic             mem_MemRead,
  input  logic [63:0]      mem_read_data,
  input  logic [SW_W-1:0]  switches,
  output logic [LED_W-1:0] leds
);

  logic [1:0]  r_state;
  logic        r_port;
  logic        r_we;
  region_e     r_region;
  logic [14:0] r_ofs;
  logic        r_mem_write, r_mem_read;
  logic [63:0] r_mem_address, r_mem_wdata;
  logic        r_done0, r_done1, r_err0, r_err1;
  logic [63:0] r_rdata0, r_rdata1;

  logic        w_any_valid, w_grant, w_win_we, w_led_we, w_unused_addr_hi;
  logic [63:0] w_win_addr, w_win_wdata, w_result, w_mmio_rdata;
  region_e     w_win_region;

  assign w_any_valid = r0_valid | r1_valid;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic r_rr_ptr;

  // On contention the port not served last wins
  always_comb begin
    w_grant = 1'b0;
    if (r0_valid && r1_valid) begin
      w_grant = r_rr_ptr;
    end else begin
      w_grant = ~r0_valid & r1_valid;
    end
  end

  // Pointer moves away from whichever port was just granted
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_any_valid) begin
      r_rr_ptr <= ~w_grant;
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end
`else
  assign w_grant = ~r0_valid & r1_valid;
`endif

  // Winner payload mux
  always_comb begin
    w_win_addr  = r0_addr;
    w_win_wdata = r0_wdata;
    w_win_we    = r0_we;
    if (w_grant) begin
      w_win_addr  = r1_addr;
      w_win_wdata = r1_wdata;
      w_win_we    = r1_we;
    end else begin
      w_win_addr  = r0_addr;
      w_win_wdata = r0_wdata;
      w_win_we    = r0_we;
    end
  end

  assign w_win_region     = decode_region(w_win_addr[31:15]);
  assign w_unused_addr_hi = ^w_win_addr[63:32];

  assign w_led_we = (r_state == ST_ISSUE) && (r_region == RGN_MMIO) && r_we &&
                    (r_ofs == MMIO_LED_OFS);

  dmem_mmio_regs #(
    .LED_W (LED_W),
    .SW_W  (SW_W)
  ) u_mmio (
    .clock       (clock),
    .reset       (reset),
    .i_switches  (switches),
    .i_led_we    (w_led_we),
    .i_led_wdata (r_mem_wdata[LED_W-1:0]),
    .o_leds      (leds),
    .o_rdata     (w_mmio_rdata)
  );

  // Result of the access in flight; stores and error accesses return zero
  always_comb begin
    w_result = 64'h0;
    if (r_we) begin
      w_result = 64'h0;
    end else begin
      case (r_region)
        RGN_DMEM: w_result = mem_read_data;
        RGN_MMIO: w_result = w_mmio_rdata;
        default:  w_result = 64'h0;
      endcase
    end
  end

  // IDLE -> ISSUE -> DONE sequencer; memory strobes are registered at the grant edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_port        <= 1'b0;
      r_we          <= 1'b0;
      r_region      <= RGN_DMEM;
      r_ofs         <= 15'h0;
      r_mem_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_address <= 64'h0;
      r_mem_wdata   <= 64'h0;
      r_done0       <= 1'b0;
      r_done1       <= 1'b0;
      r_err0        <= 1'b0;
      r_err1        <= 1'b0;
      r_rdata0      <= 64'h0;
      r_rdata1      <= 64'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_valid) begin
            r_state       <= ST_ISSUE;
            r_port        <= w_grant;
            r_we          <= w_win_we;
            r_region      <= w_win_region;
            r_ofs         <= w_win_addr[14:0];
            r_mem_address <= {{(64-ADDR_BITS){1'b0}}, w_win_addr[ADDR_BITS-1:0]};
            r_mem_wdata   <= w_win_wdata;
            r_mem_write   <= (w_win_region == RGN_DMEM) & w_win_we;
            r_mem_read    <= (w_win_region == RGN_DMEM) & ~w_win_we;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          r_mem_write <= 1'b0;
          r_mem_read  <= 1'b0;
          if (r_port) begin
            r_rdata1 <= w_result;
            r_done1  <= 1'b1;
            r_err1   <= (r_region == RGN_ERR);
          end else begin
            r_rdata0 <= w_result;
            r_done0  <= 1'b1;
            r_err0   <= (r_region == RGN_ERR);
          end
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_err0  <= 1'b0;
          r_err1  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign r0_done        = r_done0;
  assign r1_done        = r_done1;
  assign r0_err         = r_err0;
  assign r1_err         = r_err1;
  assign r0_rdata       = r_rdata0;
  assign r1_rdata       = r_rdata1;
  assign r0_stall       = r0_valid & ~r_done0;
  assign mem_address    = r_mem_address;
  assign mem_write_data = r_mem_wdata;
  assign mem_MemWrite   = r_mem_write;
  assign mem_MemRead    = r_mem_read;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port `data_memory`, shared by the pipeline MEM stage (port 0) and a secondary master such as a program loader or debug port (port 1). It latches one request and drives the memory port for exactly one cycle, then returns read data with a one-cycle done pulse. It also decodes the board I/O window: switch inputs are read there and the LED register is written there.

## Interface
Parameters:
- `ADDR_BITS`, 14: memory word-index bits taken from `addr[ADDR_BITS-1:0]`.
- `LED_W`, 27: LED register width.
- `SW_W`, 18: switch input width.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `r0_valid`, `r1_valid`  in  1: request pending. Held with its payload until the matching done.
- `r0_addr`, `r1_addr`  in  64: byte/word address as issued by the requester.
- `r0_wdata`, `r1_wdata`  in  64: store data.
- `r0_we`, `r1_we`  in  1: 1 = store, 0 = load.
- `r0_done`, `r1_done`  out  1: one-cycle completion pulse.
- `r0_rdata`, `r1_rdata`  out  64: load result. Valid while done is high, then held.
- `r0_err`, `r1_err`  out  1: high with done when the address decodes to no region.
- `r0_stall`  out  1: `r0_valid & ~r0_done`, for the pipeline hazard unit.
- `mem_address`  out  64: to the data memory.
- `mem_write_data`  out  64: to the data memory.
- `mem_MemWrite`, `mem_MemRead`  out  1: to the data memory.
- `mem_read_data`  in  64: from the data memory, combinational on address.
- `switches`  in  `SW_W`: asynchronous board inputs.
- `leds`  out  `LED_W`: registered LED drive.

## Operation
- Region is decoded from `addr[31:15]`:
  - 0 is DMEM.
  - 1 is MMIO.
  - Anything else is an error.
- FSM states are IDLE, ISSUE and DONE.
- IDLE:
  - If any valid is high, pick a winner, latch its addr/wdata/we/port id, and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE, which lasts one cycle:
  - DMEM access: `mem_address` = latched addr, and exactly one of `mem_MemWrite`/`mem_MemRead` is high.
  - MMIO load: result is `{46'b0, sw_sync}`, where `sw_sync` is the 2-flop synchronized switches.
  - MMIO store to offset 0 (`addr[14:0]==0`): `leds <= wdata[LED_W-1:0]`. MMIO stores to other offsets are ignored.
  - Error region: no memory strobe, result is 0, err is set.
  - At the end of the cycle, capture the result into the winner's rdata register and go to DONE.
- DONE, which lasts one cycle:
  - Winner's done is 1, and err is 1 if set. Memory strobes are 0.
  - Go to IDLE.
- Arbitration without the macro: fixed priority, port 0 wins over port 1.
- Stores return rdata = 0.
- The non-winning port's rdata is untouched.

## Timing
- Reset values:
  - State IDLE.
  - All done/err = 0, all rdata = 0.
  - `mem_MemWrite` = `mem_MemRead` = 0, `mem_address` = `mem_write_data` = 0.
  - `leds` = 0, sync flops 0, round-robin pointer favours port 0.
- Latency:
  - Valid is sampled at edge E0 (IDLE).
  - Memory strobes are driven in cycle E0..E1.
  - Done is high in cycle E1..E2.
  - The requester drops or changes valid at E2.
  - The earliest next grant is at E3, so peak throughput is one access per 3 cycles.
- Memory signals are registered outputs. The memory write commits at E1.
- Both valids high at E0: one winner; the loser waits, and its stall/valid stays high.
- Valid dropped after E0: protocol violation, but the latched access still completes and done still pulses.
- Reset asserted in ISSUE: strobes clear immediately, the write is not guaranteed, and no done is issued.
- A switch change is visible to loads after 2 edges of synchronizer latency.

## Configuration
- `DMEM_ARB_ROUND_ROBIN_EN`, when defined:
  - Round-robin arbitration with a 1-bit pointer that toggles to the other port after each grant.
  - When both ports are valid, the port not served last wins.
- When not defined: fixed priority to port 0, and there is no pointer flop.

## Structure
- Package `dmem_arb_pkg` holds:
  - State encoding (`ST_IDLE`, `ST_ISSUE`, `ST_DONE`).
  - Region constants `REGION_DMEM` = 17'h0 and `REGION_MMIO` = 17'h1.
  - MMIO offset `MMIO_LED_OFS` = 15'h0.
- Sub-module `dmem_mmio_regs` holds the switch 2-flop synchronizer, the LED register and the MMIO read mux. The arbiter FSM stays in the top module.

## Test plan
- Port 0 store to addr 0x10 with wdata 0xDEADBEEF, then load from 0x10:
  - `mem_MemWrite` is high exactly one cycle, one cycle after valid.
  - The load returns rdata 0xDEADBEEF with `r0_done` at E1, and `r0_stall` is high during E0..E1.
- Both ports load the same cycle, without the macro: port 0 done first and port 1 done 3 cycles later. Repeated back-to-back port 0 requests starve port 1.
- Same as the previous case with `DMEM_ARB_ROUND_ROBIN_EN`: grants alternate 0,1,0,1 under continuous dual requests.
- MMIO:
  - Store 0x5A5A to 0x8000 gives `leds` = 0x5A5A after E1.
  - Switches set to 0x3FFFF, then a load from 0x8000 after 2 cycles returns 0x3FFFF.
- Load from 0x20000 (region 4): err = 1 and rdata = 0 with done, and no memory strobe.
- Reset pulsed during ISSUE of a store:
  - Outputs return to reset values asynchronously, and `leds` = 0.
  - No done is seen, and the next request after release completes normally.
